// File: rtl/string_print_arbiter.sv
// Round-robin arbiter that streams NUL-terminated ROM strings to a shared UART,
// optionally appending a CRLF string, with a length guard against missing terminators.
module string_print_arbiter #(
  parameter int                N_REQ     = 4,
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] CRLF_ADDR = {ADDR_W{1'b0}},
  parameter int                MAX_LEN   = 255
) (
  input  logic                      clk,
  input  logic                      resetq,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_crlf,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [7:0]                rom_data,
  output logic                      uart_wr,
  input  logic                      uart_busy
);

  localparam int                OWN_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, CHECK = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [OWN_W-1:0]    owner_r, owner_s;
  logic [OWN_W-1:0]    rr_r, rr_s;
  logic                crlf_r, crlf_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [7:0]          len_r, len_s;
  logic [N_REQ-1:0]    grant_r, grant_s;
  logic [N_REQ-1:0]    done_r, done_s;
  logic                err_r, err_s;
  logic                wr_r, wr_s;
  logic                busy_r;
  logic                found_s;
  logic [OWN_W-1:0]    pick_s;
  logic [OWN_W-1:0]    cand_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic                sel_crlf_s;

  // Next-state and next-output logic; round-robin scan starts just after the last owner.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_s       = rr_r;
    crlf_s     = crlf_r;
    addr_s     = addr_r;
    len_s      = len_r;
    grant_s    = {N_REQ{1'b0}};
    done_s     = {N_REQ{1'b0}};
    err_s      = 1'b0;
    wr_s       = 1'b0;
    found_s    = 1'b0;
    pick_s     = rr_r;
    cand_s     = rr_r;
    sel_addr_s = {ADDR_W{1'b0}};
    sel_crlf_s = 1'b0;

    for (int k = 0; k < N_REQ; k++) begin
      cand_s = OWN_W'((int'(rr_r) + 1 + k) % N_REQ);
      if (req[cand_s] && !found_s) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (OWN_W'(i) == pick_s) begin
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_crlf_s = req_crlf[i];
      end else begin
        sel_crlf_s = sel_crlf_s;
      end
    end

    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s         = GAP;
          owner_s         = pick_s;
          rr_s            = pick_s;
          crlf_s          = sel_crlf_s;
          addr_s          = sel_addr_s;
          len_s           = 8'd0;
          grant_s[pick_s] = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        state_s = CHECK;
      end
      CHECK: begin
        if (rom_data != 8'h00) begin
          if (len_r == MAX_LEN_B) begin
            done_s[owner_r] = 1'b1;
            err_s           = 1'b1;
            state_s         = IDLE;
          end else if (!uart_busy) begin
            wr_s    = 1'b1;
            addr_s  = addr_r + ADDR_ONE;
            len_s   = len_r + 8'd1;
            state_s = GAP;
          end else begin
            state_s = CHECK;
          end
        end else if (crlf_r) begin
          addr_s  = CRLF_ADDR;
          crlf_s  = 1'b0;
          state_s = GAP;
        end else begin
          done_s[owner_r] = 1'b1;
          state_s         = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_r <= IDLE;
      owner_r <= {OWN_W{1'b0}};
      rr_r    <= OWN_W'(N_REQ - 1);
      crlf_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      len_r   <= 8'd0;
      grant_r <= {N_REQ{1'b0}};
      done_r  <= {N_REQ{1'b0}};
      err_r   <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      rr_r    <= rr_s;
      crlf_r  <= crlf_s;
      addr_r  <= addr_s;
      len_r   <= len_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      err_r   <= err_s;
      wr_r    <= wr_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign rom_addr = addr_r;
  assign uart_wr  = wr_r;

endmodule

// File: tb/tb_string_print_arbiter.sv
// Directed bench for string_print_arbiter with a synchronous ROM model and a
// simple UART busy model; MAX_LEN is set to 4 to reach the length guard quickly.
module tb_string_print_arbiter;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [35:0] req_addr = 36'h0;
  logic [3:0]  req_crlf = 4'h0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        uart_wr;
  logic        uart_busy;

  logic [7:0]  rom [0:511];
  logic [2:0]  ucnt = 3'd0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  byte_q [$];
  logic [3:0]  grant_q [$];
  logic [3:0]  done_q [$];
  int          grant_cyc = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [8:0]  addr;
    logic        crlf;
    int          n;
    logic [39:0] bytes;
    logic        err;
    int          gap;
  } vec_t;

  vec_t vecs [7];

  string_print_arbiter #(
    .N_REQ(4), .ADDR_W(9), .CRLF_ADDR(9'h000), .MAX_LEN(4)
  ) dut (
    .clk(clk), .resetq(resetq), .req(req), .req_addr(req_addr), .req_crlf(req_crlf),
    .grant(grant), .done(done), .err(err), .busy(busy), .rom_addr(rom_addr),
    .rom_data(rom_data), .uart_wr(uart_wr), .uart_busy(uart_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // UART stays busy for three cycles after each write strobe
  always @(posedge clk) begin
    if (!resetq) ucnt <= 3'd0;
    else if (uart_wr) ucnt <= 3'd3;
    else if (ucnt != 3'd0) ucnt <= ucnt - 3'd1;
  end
  assign uart_busy = (ucnt != 3'd0);

  always @(negedge clk) begin
    if (uart_wr === 1'b1) byte_q.push_back(rom_data);
    if (grant !== 4'h0) begin
      grant_q.push_back(grant);
      grant_cyc = cyc;
    end
    if (done !== 4'h0) begin
      done_q.push_back(done);
      done_cyc = cyc;
      done_err = err;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int t;
    byte_q.delete();
    grant_q.delete();
    done_q.delete();
    req_addr = {4{v.addr}};
    req_crlf = {4{v.crlf}};
    req = v.req;
    t = 0;
    while (grant_q.size() == 0 && t < 20) begin
      tick();
      t++;
    end
    req = 4'h0;
    chk($sformatf("v%0d_grant_cnt", id), 32'(grant_q.size()), 32'd1);
    if (grant_q.size() > 0) chk($sformatf("v%0d_grant", id), 32'(grant_q[0]), 32'(v.req));
    t = 0;
    while (done_q.size() == 0 && t < 100) begin
      tick();
      t++;
    end
    chk($sformatf("v%0d_done_cnt", id), 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      chk($sformatf("v%0d_done", id), 32'(done_q[0]), 32'(v.req));
      chk($sformatf("v%0d_err", id), 32'(done_err), 32'(v.err));
      if (v.gap > 0) chk($sformatf("v%0d_gap", id), 32'(done_cyc - grant_cyc), 32'(v.gap));
    end
    chk($sformatf("v%0d_nbytes", id), 32'(byte_q.size()), 32'(v.n));
    for (int i = 0; i < v.n && i < byte_q.size(); i++)
      chk($sformatf("v%0d_byte%0d", id, i), 32'(byte_q[i]), 32'(v.bytes[8*i +: 8]));
    tick();
    chk($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    logic [3:0] e;
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    rom[9'h000] = 8'h0D; rom[9'h001] = 8'h0A;
    rom[9'h010] = 8'h48; rom[9'h011] = 8'h69;
    for (int i = 0; i < 8; i++) rom[9'h030 + i] = 8'h41 + 8'(i);
    rom[9'h040] = 8'h41; rom[9'h041] = 8'h42; rom[9'h042] = 8'h43;
    rom[9'h1FF] = 8'h5A;

    vecs[0] = '{4'b0001, 9'h010, 1'b0, 2, 40'h00_0000_6948, 1'b0, 0};
    vecs[1] = '{4'b0001, 9'h010, 1'b1, 4, 40'h00_0A0D_6948, 1'b0, 0};
    vecs[2] = '{4'b0100, 9'h020, 1'b0, 0, 40'h00_0000_0000, 1'b0, 2};
    vecs[3] = '{4'b0100, 9'h020, 1'b1, 2, 40'h00_0000_0A0D, 1'b0, 0};
    vecs[4] = '{4'b1000, 9'h030, 1'b0, 4, 40'h00_4443_4241, 1'b1, 0};
    vecs[5] = '{4'b0010, 9'h040, 1'b1, 4, 40'h00_0D43_4241, 1'b1, 0};
    vecs[6] = '{4'b0010, 9'h1FF, 1'b0, 3, 40'h00_000A_0D5A, 1'b0, 0};

    // Requests held on all four lines straight out of reset
    resetq = 1'b0;
    req = 4'hF;
    req_addr = {4{9'h010}};
    req_crlf = 4'h0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_uart_wr", 32'(uart_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    byte_q.delete();
    grant_q.delete();
    done_q.delete();
    resetq = 1'b1;
    t = 0;
    while (grant_q.size() < 5 && t < 400) begin
      tick();
      t++;
    end
    req = 4'h0;
    t = 0;
    while (done_q.size() < 5 && t < 200) begin
      tick();
      t++;
    end
    chk("rr_grant_cnt", 32'(grant_q.size()), 32'd5);
    chk("rr_done_cnt", 32'(done_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      e = 4'b0001 << (i % 4);
      if (i < grant_q.size()) chk($sformatf("rr_grant%0d", i), 32'(grant_q[i]), 32'(e));
      if (i < done_q.size()) chk($sformatf("rr_done%0d", i), 32'(done_q[i]), 32'(e));
    end
    chk("rr_nbytes", 32'(byte_q.size()), 32'd10);
    tick();

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Reset asserted while the third character strobe is on the UART
    byte_q.delete();
    grant_q.delete();
    done_q.delete();
    req_addr = {4{9'h030}};
    req_crlf = 4'h0;
    req = 4'b0001;
    t = 0;
    while (!(uart_wr === 1'b1 && byte_q.size() == 2) && t < 100) begin
      tick();
      if (grant_q.size() != 0) req = 4'h0;
      t++;
    end
    chk("mid_reached", 32'(byte_q.size()), 32'd2);
    chk("mid_wr_before", 32'(uart_wr), 32'd1);
    req = 4'h0;
    resetq = 1'b0;
    tick();
    chk("mid_uart_wr", 32'(uart_wr), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rom_addr", 32'(rom_addr), 32'd0);
    tick();
    resetq = 1'b1;
    repeat (8) tick();
    chk("mid_no_done", 32'(done_q.size()), 32'd0);
    run_vec(vecs[0], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
